dsp_mac_engine: RTL

//  Parametrised, fully pipelined multiply/accumulate slice: next-generation DSP block.

---
 rtl/dsp_mac_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_engine.sv
// Three-stage pipelined multiply/accumulate slice with pre-adder, valid/ready
// backpressure, optional saturation and masked pattern detect on the result.
module dsp_mac_engine #(
   parameter int                 A_W      = 25,
   parameter int                 B_W      = 18,
   parameter int                 ACC_W    = 48,
   parameter bit                 SAT_EN   = 1'b1,
   parameter logic [ACC_W-1:0]   PATTERN  = {ACC_W{1'b0}},
   parameter logic [ACC_W-1:0]   PAT_MASK = {ACC_W{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   input  logic [ACC_W-1:0] c,
   input  logic [A_W-1:0]   d,
   input  logic             use_d,
   input  logic [2:0]       op,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] p,
   output logic             overflow,
   output logic             pattern_det
);

   localparam int A1_W = A_W + 1;
   localparam int M_W  = A_W + 1 + B_W;
   localparam int X_W  = ACC_W + 1;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MADD   = 3'd1;
   localparam logic [2:0] OP_MSUB   = 3'd2;
   localparam logic [2:0] OP_MAC    = 3'd3;
   localparam logic [2:0] OP_MACSUB = 3'd4;
   localparam logic [2:0] OP_AND    = 3'd5;
   localparam logic [2:0] OP_XOR    = 3'd6;
   localparam logic [2:0] OP_PASSC  = 3'd7;

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                    stall_s;
   logic                    advance_s;

   logic                    s1_valid_r;
   logic signed [A_W-1:0]   a1_r;
   logic signed [B_W-1:0]   b1_r;
   logic signed [ACC_W-1:0] c1_r;
   logic signed [A_W-1:0]   d1_r;
   logic                    use_d1_r;
   logic [2:0]              op1_r;
   logic                    clr1_r;

   logic signed [A1_W-1:0]  pre_add_s;
   logic signed [M_W-1:0]   prod_s;
   logic [ACC_W-1:0]        ab_s;

   logic                    s2_valid_r;
   logic signed [M_W-1:0]   m2_r;
   logic signed [ACC_W-1:0] c2_r;
   logic [ACC_W-1:0]        ab2_r;
   logic [2:0]              op2_r;
   logic                    clr2_r;

   logic signed [X_W-1:0]   m_x_s;
   logic signed [X_W-1:0]   c_x_s;
   logic signed [X_W-1:0]   acc_x_s;
   logic signed [X_W-1:0]   wide_s;
   logic                    arith_s;
   logic                    ovf_s;
   logic [ACC_W-1:0]        res_s;
   logic                    is_acc_op_s;
   logic                    pat_s;

   logic signed [ACC_W-1:0] acc_r;
   logic                    out_valid_r;
   logic [ACC_W-1:0]        p_r;
   logic                    overflow_r;
   logic                    pattern_det_r;

   assign stall_s   = out_valid_r & ~out_ready;
   assign advance_s = ~stall_s;
   assign in_ready  = advance_s;

   // Stage 1: capture the operand beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         a1_r       <= {A_W{1'b0}};
         b1_r       <= {B_W{1'b0}};
         c1_r       <= {ACC_W{1'b0}};
         d1_r       <= {A_W{1'b0}};
         use_d1_r   <= 1'b0;
         op1_r      <= 3'd0;
         clr1_r     <= 1'b0;
      end else if (advance_s) begin
         s1_valid_r <= in_valid;
         a1_r       <= a;
         b1_r       <= b;
         c1_r       <= c;
         d1_r       <= d;
         use_d1_r   <= use_d;
         op1_r      <= op;
         clr1_r     <= acc_clr;
      end
   end

   // Pre-adder, signed multiplier and the {a,b} logic operand.
   always_comb begin
      if (use_d1_r) begin
         pre_add_s = A1_W'(a1_r) + A1_W'(d1_r);
      end else begin
         pre_add_s = A1_W'(a1_r);
      end
      prod_s = M_W'(pre_add_s) * M_W'(b1_r);
      ab_s   = ACC_W'({a1_r, b1_r});
   end

   // Stage 2: register the product and the operands the ALU still needs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         m2_r       <= {M_W{1'b0}};
         c2_r       <= {ACC_W{1'b0}};
         ab2_r      <= {ACC_W{1'b0}};
         op2_r      <= 3'd0;
         clr2_r     <= 1'b0;
      end else if (advance_s) begin
         s2_valid_r <= s1_valid_r;
         m2_r       <= prod_s;
         c2_r       <= c1_r;
         ab2_r      <= ab_s;
         op2_r      <= op1_r;
         clr2_r     <= clr1_r;
      end
   end

   // ALU: one extra bit of headroom exposes signed overflow of the add/sub ops.
   always_comb begin
      m_x_s   = X_W'(m2_r);
      c_x_s   = X_W'(c2_r);
      acc_x_s = clr2_r ? {X_W{1'b0}} : X_W'(acc_r);
      wide_s  = {X_W{1'b0}};
      arith_s = 1'b0;
      res_s   = {ACC_W{1'b0}};
      ovf_s   = 1'b0;
      case (op2_r)
         OP_MUL:    res_s = m_x_s[ACC_W-1:0];
         OP_MADD:   begin wide_s = c_x_s + m_x_s;   arith_s = 1'b1; end
         OP_MSUB:   begin wide_s = c_x_s - m_x_s;   arith_s = 1'b1; end
         OP_MAC:    begin wide_s = acc_x_s + m_x_s; arith_s = 1'b1; end
         OP_MACSUB: begin wide_s = acc_x_s - m_x_s; arith_s = 1'b1; end
         OP_AND:    res_s = c2_r & ab2_r;
         OP_XOR:    res_s = c2_r ^ ab2_r;
         OP_PASSC:  res_s = c2_r;
         default:   res_s = c2_r;
      endcase
      if (arith_s) begin
         ovf_s = wide_s[ACC_W] ^ wide_s[ACC_W-1];
         if (ovf_s && SAT_EN) begin
            res_s = wide_s[ACC_W] ? SAT_MIN : SAT_MAX;
         end else begin
            res_s = wide_s[ACC_W-1:0];
         end
      end else begin
         ovf_s = 1'b0;
      end
      is_acc_op_s = (op2_r == OP_MAC) || (op2_r == OP_MACSUB);
      pat_s       = ((res_s & ~PAT_MASK) == (PATTERN & ~PAT_MASK));
   end

   // Stage 3: result registers and accumulator; results hold while idle or stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r   <= 1'b0;
         p_r           <= {ACC_W{1'b0}};
         overflow_r    <= 1'b0;
         pattern_det_r <= 1'b0;
         acc_r         <= {ACC_W{1'b0}};
      end else if (advance_s) begin
         out_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            p_r           <= res_s;
            overflow_r    <= ovf_s;
            pattern_det_r <= pat_s;
            if (is_acc_op_s) begin
               acc_r <= res_s;
            end
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign p           = p_r;
   assign overflow    = overflow_r;
   assign pattern_det = pattern_det_r;

endmodule
